// File: rtl/serializer_pkg.sv
// Shared types and defaults for the block serializer.
// Optional byte swap is selected by BLOCK_SERIALIZER_BYTE_SWAP_EN in the top.
package serializer_pkg;

  localparam int DEF_LENGTH = 512;
  localparam int DEF_WORD   = 32;

  typedef enum logic {IDLE, SEND} ser_state_t;

  function automatic int nwords(input int length, input int word);
    return length / word;
  endfunction

endpackage

// File: rtl/word_byte_swap.sv
// Reverses byte order within one word (byte 0 <-> byte WORD/8-1).
// Latency: combinational. Backpressure: none, pure datapath.
module word_byte_swap #(
  parameter int WORD = 32
) (
  input  logic [WORD-1:0] data_i,
  output logic [WORD-1:0] data_o
);

  localparam int NB = WORD / 8;

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign data_o[8*b +: 8] = data_i[8*(NB-1-b) +: 8];
  end

endmodule

// File: rtl/block_serializer.sv
// Serializes one LENGTH-bit block into LENGTH/WORD words, MS word first; 1 cycle load-to-first-word,
// outputs hold under !word_ready. Define BLOCK_SERIALIZER_BYTE_SWAP_EN to byte-reverse each word.
module block_serializer
  import serializer_pkg::*;
#(
  parameter int LENGTH = DEF_LENGTH,
  parameter int WORD   = DEF_WORD
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [LENGTH-1:0] load_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD-1:0]   word_data,
  output logic              word_last,
  output logic              busy
);

  localparam int NWORDS = nwords(LENGTH, WORD);
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  if (LENGTH % WORD != 0) begin : g_len_chk
    $error("block_serializer: LENGTH must be a multiple of WORD");
  end
  if (WORD % 8 != 0) begin : g_word_chk
    $error("block_serializer: WORD must be a multiple of 8");
  end

  ser_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [LENGTH-1:0] shreg_q, shreg_d;
  logic [WORD-1:0]   word_q, word_d;

  logic [LENGTH-1:0] shifted;
  logic [WORD-1:0]   raw_word;
  logic [WORD-1:0]   out_word;
  logic              word_acc;
  logic              load_acc;

  assign word_valid = (state_q == SEND);
  assign busy       = (state_q == SEND);
  assign word_last  = word_valid && (cnt_q == LAST_IDX);
  assign word_data  = word_q;

  assign word_acc   = word_valid && word_ready;
  assign load_ready = (state_q == IDLE) || (word_acc && word_last);
  assign load_acc   = load_valid && load_ready;

  // The next word comes either from a fresh block or from the shifted register top.
  assign shifted  = shreg_q << WORD;
  assign raw_word = load_acc ? load_data[LENGTH-1 -: WORD] : shifted[LENGTH-1 -: WORD];

`ifdef BLOCK_SERIALIZER_BYTE_SWAP_EN
  word_byte_swap #(.WORD(WORD)) u_swap (
    .data_i (raw_word),
    .data_o (out_word)
  );
`else
  assign out_word = raw_word;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    if (load_acc) begin
      state_d = SEND;
      cnt_d   = '0;
      shreg_d = load_data;
      word_d  = out_word;
    end else if (word_acc) begin
      if (word_last) begin
        state_d = IDLE;
      end else begin
        shreg_d = shifted;
        cnt_d   = cnt_q + 1'b1;
        word_d  = out_word;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench for block_serializer: vector table for single blocks plus
// hand-written back-to-back, ignored-load and mid-block reset sequences.
module tb_block_serializer;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         load_valid;
  logic         load_ready;
  logic [511:0] load_data;
  logic         word_valid;
  logic         word_ready;
  logic [31:0]  word_data;
  logic         word_last;
  logic         busy;

  block_serializer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_last  (word_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

`ifdef BLOCK_SERIALIZER_BYTE_SWAP_EN
  localparam logic [31:0] SWAP_FIRST = 32'h44332211;
`else
  localparam logic [31:0] SWAP_FIRST = 32'h11223344;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [511:0] blk;
    int           stall_at;
    int           stall_len;
    int           exp_cycles;
    logic [31:0]  exp_first;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [511:0] b, input int i);
    logic [31:0] w;
    w = b[511-32*i -: 32];
`ifdef BLOCK_SERIALIZER_BYTE_SWAP_EN
    w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
    return w;
  endfunction

  function automatic logic [511:0] basic_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = 32'(i * 17);
    return b;
  endfunction

  task automatic push_block(input logic [511:0] b);
    for (int i = 0; i < 16; i++) sb.push_back('{d: exp_word(b, i), l: (i == 15)});
  endtask

  // Scoreboard: every accepted word must match the next expected word.
  always @(negedge clk) begin
    if (n_rst && word_valid && word_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra_word", {31'd0, word_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", word_data, e.d);
        check("sb_last", {31'd0, word_last}, {31'd0, e.l});
      end
    end
  end

  task automatic load_block(input logic [511:0] b);
    load_valid = 1'b1;
    load_data  = b;
    for (int k = 0; k < 50 && !load_ready; k++) begin
      @(posedge clk); #1;
    end
    check("load_rdy", {31'd0, load_ready}, 32'd1);
    if (load_ready) push_block(b);
    @(posedge clk); #1;
    load_valid = 1'b0;
    check("first_vld", {31'd0, word_valid}, 32'd1);
  endtask

  task automatic run_block(input logic [511:0] b, input int stall_at, input int stall_len,
                           input int pulse_at, output int cycles);
    int widx;
    int left;
    widx   = 0;
    left   = stall_len;
    cycles = 0;
    load_data = ~b;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      cycles++;
      load_valid = (widx == pulse_at);
      if (widx == pulse_at) check("ign_rdy", {31'd0, load_ready}, 32'd0);
      if (widx == stall_at && left > 0) begin
        word_ready = 1'b0;
        left--;
        check("hold_data", word_data, exp_word(b, widx));
        check("hold_last", {31'd0, word_last}, {31'd0, widx == 15});
      end else begin
        word_ready = 1'b1;
        widx++;
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    word_ready = 1'b1;
    check("idle_vld", {31'd0, word_valid}, 32'd0);
  endtask

  initial begin
    logic [511:0] a_blk;
    logic [511:0] b_blk;
    logic [511:0] s_blk;
    logic [511:0] r_blk;
    int cyc;
    bit b_loaded;

    a_blk = basic_block();
    b_blk = {16{32'hA5A5A5A5}};
    s_blk = a_blk;
    s_blk[511 -: 32] = 32'h11223344;
    for (int i = 0; i < 16; i++) r_blk[32*i +: 32] = $urandom;

    vecs[0] = '{blk: a_blk, stall_at: -1, stall_len: 0, exp_cycles: 16, exp_first: 32'h00000000};
    vecs[1] = '{blk: a_blk, stall_at: 5,  stall_len: 3, exp_cycles: 19, exp_first: 32'h00000000};
    vecs[2] = '{blk: s_blk, stall_at: -1, stall_len: 0, exp_cycles: 16, exp_first: SWAP_FIRST};
    vecs[3] = '{blk: r_blk, stall_at: 15, stall_len: 2, exp_cycles: 18, exp_first: exp_word(r_blk, 0)};

    n_rst      = 1'b0;
    load_valid = 1'b0;
    word_ready = 1'b0;
    load_data  = '0;
    #12;
    check("rst_vld",  {31'd0, word_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_last", {31'd0, word_last}, 32'd0);
    check("rst_data", word_data, 32'd0);
    check("rst_lrdy", {31'd0, load_ready}, 32'd1);
    @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b1;

    for (int v = 0; v < 4; v++) begin
      load_block(vecs[v].blk);
      check("first_word", word_data, vecs[v].exp_first);
      run_block(vecs[v].blk, vecs[v].stall_at, vecs[v].stall_len, -1, cyc);
      check("blk_cycles", cyc, vecs[v].exp_cycles);
    end

    // Back-to-back: second block loaded during the last-word accept, no bubble.
    load_block(a_blk);
    cyc = 0;
    b_loaded = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!word_valid) break;
      cyc++;
      if (word_last && !b_loaded) begin
        load_valid = 1'b1;
        load_data  = b_blk;
        check("b2b_lrdy", {31'd0, load_ready}, 32'd1);
        push_block(b_blk);
        b_loaded = 1'b1;
      end else begin
        load_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    check("b2b_cycles", cyc, 32);

    // Load pulse mid-block must be ignored.
    load_block(a_blk);
    run_block(a_blk, -1, 0, 7, cyc);
    check("ign_cycles", cyc, 16);
    @(posedge clk); #1;
    check("ign_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset at word 9, then restart from word 0.
    load_block(a_blk);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_word", word_data, exp_word(a_blk, 9));
    #2;
    n_rst = 1'b0;
    #1;
    check("mid_rst_vld",  {31'd0, word_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_last", {31'd0, word_last}, 32'd0);
    check("mid_rst_data", word_data, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    load_block(r_blk);
    check("post_rst_word0", word_data, exp_word(r_blk, 0));
    run_block(r_blk, -1, 0, -1, cyc);
    check("post_rst_cycles", cyc, 16);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_serializer.md
Name: block_serializer

Overview:
- Transmit-side companion to the block reformatting path. Accepts one LENGTH-bit block, such as a SHA-256 message block or header chunk, through a valid/ready load port.
- Emits the block as NWORDS = LENGTH/WORD words over a valid/ready stream, most-significant word first.
- Sits between the block-assembly logic and word-wide consumers: the hash core message scheduler and the host readback path.

Parameters:
LENGTH, 512, total block width in bits; must be a multiple of WORD.
WORD, 32, output word width in bits; must be a multiple of 8.

Ports:
clk  input  1  system clock, rising edge.
n_rst  input  1  asynchronous active-low reset.
load_valid  input  1  load_data is valid.
load_ready  output  1  serializer can accept a block this cycle.
load_data  input  LENGTH  block to serialize.
word_valid  output  1  word_data is valid.
word_ready  input  1  consumer accepts word this cycle.
word_data  output  WORD  current output word.
word_last  output  1  current word is the final word of the block.
busy  output  1  a block is in flight.

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE, word_valid=0, word_data=0, word_last=0, busy=0, word counter=0, shift register=0. load_ready reads 1 while in IDLE.
- States:
  - IDLE: no block held.
  - SEND: block held; words being presented.
- Handshakes: load accepted when load_valid&&load_ready; word accepted when word_valid&&word_ready.
- load_ready (combinational) = (state==IDLE) || (word_valid && word_ready && word_last).
- IDLE -> SEND on load accept. On the next edge:
  - shift register <= load_data;
  - word_data <= load_data[LENGTH-1 -: WORD];
  - word_valid=1, counter=0, busy=1.
  - Latency from load accept to first valid word: 1 cycle.
- In SEND, on word accept with counter < NWORDS-1:
  - shift register shifts left by WORD;
  - word_data <= next WORD bits;
  - counter+1.
- word_last = word_valid && (counter==NWORDS-1).
- Last-word accept with no simultaneous load: -> IDLE, word_valid=0, busy=0. word_data keeps its last value; it is don't-care.
- Last-word accept with simultaneous load accept: stay in SEND and load the new block exactly as from IDLE. There is no bubble cycle, so throughput is NWORDS cycles per block.
- Backpressure: while word_valid && !word_ready, word_data, word_last and counter are held stable.
- load_valid while not load_ready is ignored, and load_data is not sampled.
- Full rate: with word_ready held high, one word per cycle.
- NWORDS==1 is legal: word_last is asserted on the only word.
- Counter width is $clog2(NWORDS), minimum 1. The counter never wraps past NWORDS-1 within a block.
- Reset mid-block: the block is discarded immediately and the next block starts at word 0.

Optional Feature:
- Macro: BLOCK_SERIALIZER_BYTE_SWAP_EN.
- Defined: each emitted word has its byte order reversed (byte 0 <-> byte WORD/8-1), applied combinationally between the shift register top and the word_data register. Latency is unchanged.
- Undefined: words are emitted with native byte order. No swap logic is synthesized.

Decomposition:
- Package serializer_pkg holds:
  - localparam defaults for LENGTH and WORD;
  - function nwords(LENGTH, WORD);
  - the state typedef enum logic {IDLE, SEND} ser_state_t.
- Elaboration-time checks (LENGTH%WORD==0, WORD%8==0) are $error in the module.
- One natural sub-module, word_byte_swap (parameter WORD, purely combinational), instantiated only under the macro.

Test Plan:
- Basic serialize: load 512-bit block whose word i (from MSB) = 0x000000i0+i, i=0..15, with word_ready=1 -> words 0x00000000, 0x00000011 … 0x000000FF on 16 consecutive cycles starting 1 cycle after load. word_last only on 0x000000FF; busy drops the cycle after.
- Backpressure: same block, word_ready low for 3 cycles at word 5 -> word_data holds 0x00000055 and word_last=0 throughout; sequence resumes unchanged.
- Back-to-back: second block (all words 0xA5A5A5A5) presented with load_valid during the last-word accept -> load_ready=1 that cycle. The next cycle shows 0xA5A5A5A5 with no gap; 32 words total in 32 cycles.
- Load ignored: load_valid pulsed mid-block at word 7 -> load_ready=0, output sequence unaffected, no new block started.
- Reset mid-block: n_rst low at word 9 -> word_valid, busy, word_last and word_data go to 0 asynchronously. A new load after release restarts at word 0.
- Byte swap (macro defined): word 0x11223344 in block MSB -> first emitted word 0x44332211. Without macro -> 0x11223344.
